// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, oversampling defaults and the
// parity helper used by both the transmitter and the receiver.
package uart_pkg;

  localparam int unsigned NB_STATE = 3;

  typedef enum logic [NB_STATE-1:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_t;

  localparam int unsigned OVERSAMPLE_DEFAULT = 16;
  localparam int unsigned MID_SAMPLE         = OVERSAMPLE_DEFAULT / 2 - 1;

  // Widest data word the parity helper accepts; narrower words are zero-extended.
  localparam int unsigned NB_PARITY_MAX = 16;

  // Expected parity bit: even -> ^data, odd -> ~^data.
  function automatic logic uart_parity(input logic [NB_PARITY_MAX-1:0] data,
                                       input logic                     even);
    return even ? ^data : ~^data;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line. Resets to 1 so the
// line reads as idle while reset is held. The module exists only when
// UART_RX_SYNC_EN is defined, matching its single instantiation in uart_rx.
`ifdef UART_RX_SYNC_EN
module uart_rx_sync (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_data,
  output logic o_data
);

  logic meta;

  // Two-stage resynchronization of the raw line into the i_clock domain.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      meta   <= 1'b1;
      o_data <= 1'b1;
    end else begin
      meta   <= i_data;
      o_data <= meta;
    end
  end

endmodule
`endif

// File: rtl/uart_rx.sv
// UART receiver: 16x-oversampled start/data/parity/stop recovery, paced by the
// i_valid baud tick. Each frame is presented with a one-cycle o_rx_done pulse
// and sticky-until-next-frame error flags.
// Build option: UART_RX_SYNC_EN inserts a 2-flop synchronizer on i_data.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned NB_DATA         = 8,
  parameter int unsigned N_DATA          = 8,
  parameter int unsigned PARITY_CHECK    = 1,
  parameter int unsigned EVEN_ODD_PARITY = 1,
  parameter int unsigned M_STOP          = 1,
  parameter int unsigned OVERSAMPLE      = OVERSAMPLE_DEFAULT
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_data,
  input  logic               i_valid,
  output logic [NB_DATA-1:0] o_data,
  output logic               o_rx_done,
  output logic               o_parity_error,
  output logic               o_frame_error
);

  localparam int unsigned TICK_W = $clog2(OVERSAMPLE);
  localparam int unsigned BIT_W  = $clog2(N_DATA + 1);
  localparam int unsigned STOP_W = $clog2(M_STOP + 1);

  // The first low tick is consumed in ST_IDLE, so the start-bit counter reaches
  // the mid-bit tick (OVERSAMPLE/2-1) one count early.
  localparam logic [TICK_W-1:0] START_LAST = TICK_W'(OVERSAMPLE / 2 - 2);
  localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(OVERSAMPLE - 1);
  localparam logic [TICK_W-1:0] TICK_ONE   = TICK_W'(1);
  localparam logic [BIT_W-1:0]  BIT_LAST   = BIT_W'(N_DATA - 1);
  localparam logic [BIT_W-1:0]  BIT_ONE    = BIT_W'(1);
  localparam logic [STOP_W-1:0] STOP_LAST  = STOP_W'(M_STOP - 1);
  localparam logic [STOP_W-1:0] STOP_ONE   = STOP_W'(1);

  logic line;

`ifdef UART_RX_SYNC_EN
  uart_rx_sync u_sync (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_data  (i_data),
    .o_data  (line)
  );
`else
  assign line = i_data;
`endif

  uart_state_t        state,     state_nxt;
  logic [TICK_W-1:0]  tick_cnt,  tick_nxt;
  logic [BIT_W-1:0]   bit_cnt,   bit_nxt;
  logic [STOP_W-1:0]  stop_cnt,  stop_nxt;
  logic [N_DATA-1:0]  shift_reg, shift_nxt;
  logic               par_err,   par_err_nxt;
  logic               frame_acc, frame_acc_nxt;
  logic               armed,     armed_nxt;
  logic [NB_DATA-1:0] data_nxt;
  logic               perr_nxt, ferr_nxt, done_nxt;
  logic               exp_par, frame_now;

  // State, counters, shift register and registered outputs.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state          <= ST_IDLE;
      tick_cnt       <= '0;
      bit_cnt        <= '0;
      stop_cnt       <= '0;
      shift_reg      <= '0;
      par_err        <= 1'b0;
      frame_acc      <= 1'b0;
      armed          <= 1'b1;
      o_data         <= '0;
      o_rx_done      <= 1'b0;
      o_parity_error <= 1'b0;
      o_frame_error  <= 1'b0;
    end else begin
      state          <= state_nxt;
      tick_cnt       <= tick_nxt;
      bit_cnt        <= bit_nxt;
      stop_cnt       <= stop_nxt;
      shift_reg      <= shift_nxt;
      par_err        <= par_err_nxt;
      frame_acc      <= frame_acc_nxt;
      armed          <= armed_nxt;
      o_data         <= data_nxt;
      o_rx_done      <= done_nxt;
      o_parity_error <= perr_nxt;
      o_frame_error  <= ferr_nxt;
    end
  end

  // Next-state and datapath decode; everything advances only on a baud tick.
  always_comb begin
    state_nxt     = state;
    tick_nxt      = tick_cnt;
    bit_nxt       = bit_cnt;
    stop_nxt      = stop_cnt;
    shift_nxt     = shift_reg;
    par_err_nxt   = par_err;
    frame_acc_nxt = frame_acc;
    armed_nxt     = armed;
    data_nxt      = o_data;
    perr_nxt      = o_parity_error;
    ferr_nxt      = o_frame_error;
    done_nxt      = 1'b0;
    exp_par       = uart_parity(NB_PARITY_MAX'(shift_reg), (EVEN_ODD_PARITY != 0));
    frame_now     = frame_acc | ~line;

    if (i_valid) begin
      case (state)
        ST_IDLE: begin
          // After a break the line must return high before a new start is taken.
          if (line) begin
            armed_nxt = 1'b1;
          end else if (armed) begin
            tick_nxt  = '0;
            state_nxt = ST_START;
          end
        end

        ST_START: begin
          if (tick_cnt == START_LAST) begin
            tick_nxt = '0;
            if (!line) begin
              bit_nxt       = '0;
              stop_nxt      = '0;
              par_err_nxt   = 1'b0;
              frame_acc_nxt = 1'b0;
              state_nxt     = ST_DATA;
            end else begin
              state_nxt = ST_IDLE;
            end
          end else begin
            tick_nxt = tick_cnt + TICK_ONE;
          end
        end

        ST_DATA: begin
          if (tick_cnt == TICK_LAST) begin
            tick_nxt  = '0;
            shift_nxt = (shift_reg >> 1) | (N_DATA'(line) << (N_DATA - 1));
            bit_nxt   = bit_cnt + BIT_ONE;
            if (bit_cnt == BIT_LAST) begin
              if (PARITY_CHECK != 0) state_nxt = ST_PARITY;
              else                   state_nxt = ST_STOP;
            end
          end else begin
            tick_nxt = tick_cnt + TICK_ONE;
          end
        end

        ST_PARITY: begin
          if (tick_cnt == TICK_LAST) begin
            tick_nxt    = '0;
            par_err_nxt = (line != exp_par);
            state_nxt   = ST_STOP;
          end else begin
            tick_nxt = tick_cnt + TICK_ONE;
          end
        end

        ST_STOP: begin
          if (tick_cnt == TICK_LAST) begin
            tick_nxt = '0;
            if (stop_cnt == STOP_LAST) begin
              data_nxt      = NB_DATA'(shift_reg);
              perr_nxt      = par_err;
              ferr_nxt      = frame_now;
              done_nxt      = 1'b1;
              frame_acc_nxt = frame_now;
              armed_nxt     = ~frame_now;
              state_nxt     = ST_IDLE;
            end else begin
              stop_nxt      = stop_cnt + STOP_ONE;
              frame_acc_nxt = frame_now;
            end
          end else begin
            tick_nxt = tick_cnt + TICK_ONE;
          end
        end

        default: state_nxt = ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: a table of frames with hand-computed results,
// followed by hand-written sequences for glitch, reset, break, stall,
// back-to-back and the no-parity/two-stop-bit configuration.
module tb_uart_rx;
  import uart_pkg::*;

  logic       i_clock = 1'b0;
  logic       i_reset;
  logic       i_data;
  logic       i_valid;
  logic [7:0] o_data1, o_data2;
  logic       done1, perr1, ferr1;
  logic       done2, perr2, ferr2;

  uart_rx dut (
    .i_clock        (i_clock),
    .i_reset        (i_reset),
    .i_data         (i_data),
    .i_valid        (i_valid),
    .o_data         (o_data1),
    .o_rx_done      (done1),
    .o_parity_error (perr1),
    .o_frame_error  (ferr1)
  );

  uart_rx #(.PARITY_CHECK(0), .M_STOP(2)) dut2 (
    .i_clock        (i_clock),
    .i_reset        (i_reset),
    .i_data         (i_data),
    .i_valid        (i_valid),
    .o_data         (o_data2),
    .o_rx_done      (done2),
    .o_parity_error (perr2),
    .o_frame_error  (ferr2)
  );

  always #5 i_clock = ~i_clock;

  int total = 0;
  int bad   = 0;
  int tnow  = 0;
  int gap   = 1;
  int d1_cnt = 0, d1_tick = -1;
  int d2_cnt = 0, d2_tick = -1;
  int fstart = 0;

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       stop;
    logic [7:0] exp_data;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic sample_done();
    if (done1 === 1'b1) begin d1_cnt++; d1_tick = tnow; end
    if (done2 === 1'b1) begin d2_cnt++; d2_tick = tnow; end
  endtask

  // One baud tick carrying line value v, then `gap` stalled clocks.
  task automatic tick(input logic v);
    i_data  = v;
    i_valid = 1'b1;
    @(posedge i_clock); #1;
    sample_done();
    i_valid = 1'b0;
    for (int g = 0; g < gap; g++) begin
      @(posedge i_clock); #1;
      sample_done();
    end
    tnow++;
  endtask

  task automatic send_bit(input logic v, input int len);
    for (int k = 0; k < len; k++) tick(v);
  endtask

  task automatic send_frame(input logic [7:0] d, input bit par_on, input logic par_v,
                            input int nstop, input logic stop_v, input int last_len);
    fstart = tnow;
    send_bit(1'b0, 16);
    for (int b = 0; b < 8; b++) send_bit(d[b], 16);
    if (par_on) send_bit(par_v, 16);
    for (int s = 0; s < nstop; s++) send_bit(stop_v, (s == nstop - 1) ? last_len : 16);
  endtask

  task automatic pulse_reset();
    #2 i_reset = 1'b1;
    @(posedge i_clock); #1;
    i_reset = 1'b0;
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, t1;
    vecs[0] = '{8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b0};
    vecs[2] = '{8'h3C, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1};
    vecs[3] = '{8'h55, 1'b0, 1'b1, 8'h55, 1'b0, 1'b0};
    vecs[4] = '{8'h01, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0};
    vecs[5] = '{8'h01, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0};
    vecs[6] = '{8'hFE, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0};
    vecs[7] = '{8'h80, 1'b0, 1'b0, 8'h80, 1'b1, 1'b1};

    i_reset = 1'b1;
    i_data  = 1'b1;
    i_valid = 1'b0;
    repeat (3) @(posedge i_clock);
    #1;
    check("rst_data",  o_data1, 8'h00);
    check("rst_done",  done1,   1'b0);
    check("rst_perr",  perr1,   1'b0);
    check("rst_ferr",  ferr1,   1'b0);
    check("rst_state", dut.state, ST_IDLE);
    i_reset = 1'b0;
    send_bit(1'b1, 4);

    // Table-driven frames.
    for (int i = 0; i < 8; i++) begin
      c0 = d1_cnt;
      send_frame(vecs[i].data, 1'b1, vecs[i].par, 1, vecs[i].stop, 16);
      check($sformatf("v%0d_done_cnt", i),  d1_cnt - c0,      1);
      check($sformatf("v%0d_done_tick", i), d1_tick - fstart, 167);
      check($sformatf("v%0d_data", i),      o_data1,          vecs[i].exp_data);
      check($sformatf("v%0d_perr", i),      perr1,            vecs[i].exp_perr);
      check($sformatf("v%0d_ferr", i),      ferr1,            vecs[i].exp_ferr);
      send_bit(1'b1, 4);
    end

    // Asynchronous reset during data bit 3 aborts the frame.
    c0 = d1_cnt;
    send_bit(1'b0, 16);
    send_bit(1'b1, 16 * 3);
    send_bit(1'b1, 8);
    #2 i_reset = 1'b1;
    #1;
    check("arst_data",  o_data1, 8'h00);
    check("arst_perr",  perr1,   1'b0);
    check("arst_ferr",  ferr1,   1'b0);
    check("arst_state", dut.state, ST_IDLE);
    @(posedge i_clock); #1;
    i_reset = 1'b0;
    send_bit(1'b1, 200);
    check("arst_no_done", d1_cnt - c0, 0);
    c0 = d1_cnt;
    send_frame(8'h81, 1'b1, 1'b0, 1, 1'b1, 16);
    check("post_rst_cnt",  d1_cnt - c0,      1);
    check("post_rst_tick", d1_tick - fstart, 167);
    check("post_rst_data", o_data1,          8'h81);
    check("post_rst_perr", perr1,            1'b0);
    send_bit(1'b1, 4);

    // Break: line held low completes one zero frame, then no restart while low.
    c0 = d1_cnt;
    fstart = tnow;
    send_bit(1'b0, 176);
    check("brk_cnt",  d1_cnt - c0,      1);
    check("brk_tick", d1_tick - fstart, 167);
    check("brk_data", o_data1,          8'h00);
    check("brk_perr", perr1,            1'b0);
    check("brk_ferr", ferr1,            1'b1);
    send_bit(1'b0, 200);
    check("brk_hold_cnt", d1_cnt - c0, 1);
    send_bit(1'b1, 4);
    c0 = d1_cnt;
    send_frame(8'h55, 1'b1, 1'b0, 1, 1'b1, 16);
    check("brk_rec_cnt",  d1_cnt - c0, 1);
    check("brk_rec_data", o_data1,     8'h55);
    check("brk_rec_ferr", ferr1,       1'b0);
    send_bit(1'b1, 4);

    // Four-tick low glitch: still in start at tick 6, back in idle after tick 7.
    c0 = d1_cnt;
    send_bit(1'b0, 4);
    send_bit(1'b1, 3);
    check("glitch_t6_state", dut.state, ST_START);
    send_bit(1'b1, 1);
    check("glitch_t7_state", dut.state, ST_IDLE);
    send_bit(1'b1, 200);
    check("glitch_no_done", d1_cnt - c0, 0);
    check("glitch_data",    o_data1,     8'h55);

    // Stalled ticks: five idle clocks between ticks must not move the sample points.
    gap = 5;
    c0 = d1_cnt;
    send_frame(8'hC3, 1'b1, 1'b0, 1, 1'b1, 16);
    check("stall_cnt",  d1_cnt - c0,      1);
    check("stall_tick", d1_tick - fstart, 167);
    check("stall_data", o_data1,          8'hC3);
    gap = 1;
    send_bit(1'b1, 4);

    // Back-to-back full frames, then a start right after the last stop sample.
    c0 = d1_cnt;
    send_frame(8'h00, 1'b1, 1'b0, 1, 1'b1, 16);
    check("b2b0_data", o_data1, 8'h00);
    t1 = d1_tick;
    send_frame(8'hFF, 1'b1, 1'b0, 1, 1'b1, 16);
    check("b2b_cnt",   d1_cnt - c0,  2);
    check("b2b_gap",   d1_tick - t1, 176);
    check("b2b1_data", o_data1,      8'hFF);
    send_frame(8'h0F, 1'b1, 1'b0, 1, 1'b1, 8);
    t1 = d1_tick;
    check("tight0_data", o_data1, 8'h0F);
    send_frame(8'hF0, 1'b1, 1'b0, 1, 1'b1, 16);
    check("tight_gap",   d1_tick - t1, 168);
    check("tight1_data", o_data1,      8'hF0);
    check("tight1_perr", perr1,        1'b0);
    check("tight1_ferr", ferr1,        1'b0);

    // No parity, two stop bits.
    pulse_reset();
    d2_cnt = 0;
    send_bit(1'b1, 4);
    send_frame(8'h7E, 1'b0, 1'b0, 2, 1'b1, 16);
    check("np_cnt",  d2_cnt,           1);
    check("np_tick", d2_tick - fstart, 167);
    check("np_data", o_data2,          8'h7E);
    check("np_perr", perr2,            1'b0);
    check("np_ferr", ferr2,            1'b0);
    t1 = d2_tick;
    send_frame(8'h81, 1'b0, 1'b0, 2, 1'b1, 16);
    check("np_b2b_gap",  d2_tick - t1, 176);
    check("np_b2b_data", o_data2,      8'h81);
    send_bit(1'b1, 4);
    send_frame(8'h42, 1'b0, 1'b0, 2, 1'b0, 16);
    check("np_ferr_cnt",  d2_cnt,  3);
    check("np_ferr_data", o_data2, 8'h42);
    check("np_ferr_flag", ferr2,   1'b1);
    check("np_ferr_perr", perr2,   1'b0);
    send_bit(1'b1, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
